// File: rtl/nibble_seq_pkg.sv
// Shared types and constants for the nibble-serial add/subtract sequencer.
package nibble_seq_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Width of the nibble index counter, never narrower than one bit.
  function automatic int idx_width(input int nibbles);
    return (nibbles <= 1) ? 1 : $clog2(nibbles);
  endfunction

endpackage

// File: rtl/nibble_addsub.sv
// Combinational 4-bit ripple adder slice; also exposes the carry into the top bit.
module nibble_addsub
  import nibble_seq_pkg::*;
(
  input  logic [NIBBLE_W-1:0] x,
  input  logic [NIBBLE_W-1:0] y,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] s,
  output logic                cout,
  output logic                c3
);

  logic [NIBBLE_W:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < NIBBLE_W; i++) begin : g_bit
    assign s[i]   = x[i] ^ y[i] ^ c[i];
    assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
  end

  assign cout = c[NIBBLE_W];
  assign c3   = c[NIBBLE_W-1];

endmodule

// File: rtl/nibble_seq_addsub.sv
// Wide add/subtract computed one nibble per clock through a single shared slice.
module nibble_seq_addsub
  import nibble_seq_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        sub,
  input  logic [NIBBLE_W*NIBBLES-1:0] a,
  input  logic [NIBBLE_W*NIBBLES-1:0] b,
  output logic                        busy,
  output logic                        done,
  output logic [NIBBLE_W*NIBBLES-1:0] result,
  output logic                        carry,
  output logic                        v,
  output state_e                      dbg_state
);

  // Handshake: start is taken on any edge where busy=0 (IDLE or DONE);
  // busy then stays high for exactly NIBBLES cycles, and done pulses for
  // one cycle when result/carry/v become valid. start while busy is dropped.

  localparam int W     = NIBBLE_W * NIBBLES;
  localparam int IDX_W = idx_width(NIBBLES);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NIBBLES - 1);

  state_e              state;
  logic [IDX_W-1:0]    idx;
  logic                creg;
  logic                sub_q;
  logic [W-1:0]        a_q;
  logic [W-1:0]        b_q;
  logic [W-1:0]        shreg;

  logic [NIBBLE_W-1:0] slice_s;
  logic                slice_cout;
  logic                slice_c3;

  // Operands are shifted right each step, so the active nibble is always at the bottom.
  nibble_addsub u_slice (
    .x    (a_q[NIBBLE_W-1:0]),
    .y    (b_q[NIBBLE_W-1:0] ^ {NIBBLE_W{sub_q}}),
    .cin  (creg),
    .s    (slice_s),
    .cout (slice_cout),
    .c3   (slice_c3)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      idx    <= '0;
      creg   <= 1'b0;
      sub_q  <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      shreg  <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      carry  <= 1'b0;
      v      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          done <= 1'b0;
          if (start) begin
            a_q   <= a;
            b_q   <= b;
            sub_q <= sub;
            idx   <= '0;
            creg  <= sub;
            shreg <= '0;
            busy  <= 1'b1;
            state <= ST_RUN;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          a_q   <= {{NIBBLE_W{1'b0}}, a_q[W-1:NIBBLE_W]};
          b_q   <= {{NIBBLE_W{1'b0}}, b_q[W-1:NIBBLE_W]};
          // Sum nibbles enter at the top; after NIBBLES shifts nibble 0 sits at the LSB.
          shreg <= {slice_s, shreg[W-1:NIBBLE_W]};
          creg  <= slice_cout;
          idx   <= idx + 1'b1;
          if (idx == LAST) begin
            result <= {slice_s, shreg[W-1:NIBBLE_W]};
            carry  <= slice_cout;
            v      <= slice_c3 ^ slice_cout;
            idx    <= '0;
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= ST_DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign dbg_state = state;

endmodule
